// File: rtl/dec_asc_pkg.sv
// Shared types and ASCII constants for the transmit-side BCD-to-ASCII formatter.
package dec_asc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_t;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_QMARK = 8'h3F;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

endpackage

// File: rtl/dec_to_asc.sv
// Combinational BCD digit to ASCII encoder; the inverse of the RX-side ASCII decode.
module dec_to_asc
  import dec_asc_pkg::*;
(
  input  logic [3:0] iDigit,
  output logic [7:0] oAscii,
  output logic       oInvalid
);

  always_comb begin
    oInvalid = (iDigit > 4'd9);
    oAscii   = oInvalid ? ASC_QMARK : (ASC_ZERO + {4'h0, iDigit});
  end

endmodule

// File: rtl/dec_to_asc_tx.sv
// Latches a packed BCD value and streams it MS digit first (optionally followed by CR LF)
// into uart_tx through its start/busy handshake.
module dec_to_asc_tx
  import dec_asc_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int APPEND_CRLF = 1,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iStart,
  input  logic [4*DIGITS-1:0]   iBcd,
  input  logic                  iTxBusy,
  output logic                  oTxStart,
  output logic [7:0]            oTxData,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oErr
);

  localparam int IW    = $clog2(DIGITS + 3);
  localparam int NCHAR = DIGITS + 2 * APPEND_CRLF;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHAR - 1);
  localparam logic [IW-1:0] LAST_DIG = IW'(DIGITS - 1);
  localparam logic [IW-1:0] CR_IDX   = IW'(DIGITS);

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  supp_q, supp_d;
  logic                  txstart_q, txstart_d;
  logic [7:0]            txdata_q, txdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [3:0]            dig;
  logic [7:0]            dig_asc;
  logic                  dig_bad;
  logic [7:0]            cur_char;
  logic                  skip;

  // Index 0 addresses the most significant digit.
  always_comb begin
    dig = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) dig = bcd_q[4*(DIGITS-1-i) +: 4];
    end
  end

  dec_to_asc u_conv (
    .iDigit   (dig),
    .oAscii   (dig_asc),
    .oInvalid (dig_bad)
  );

  always_comb begin
    if (idx_q < CR_IDX)       cur_char = dig_asc;
    else if (idx_q == CR_IDX) cur_char = ASC_CR;
    else                      cur_char = ASC_LF;
  end

  // Digit 0 (the last digit index) is never suppressed.
  assign skip = (LZ_SUPPRESS != 0) && supp_q && (idx_q < LAST_DIG) && (dig == 4'd0);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bcd_d     = bcd_q;
    supp_d    = supp_q;
    txstart_d = 1'b0;
    txdata_d  = txdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          bcd_d   = iBcd;
          idx_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          supp_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (skip) begin
          idx_d = idx_q + 1'b1;
        end else if (!iTxBusy) begin
          txstart_d = 1'b1;
          txdata_d  = cur_char;
          if (idx_q < CR_IDX) begin
            supp_d = 1'b0;
            if (dig_bad) err_d = 1'b1;
          end
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (iTxBusy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!iTxBusy) begin
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      bcd_q     <= '0;
      supp_q    <= 1'b0;
      txstart_q <= 1'b0;
      txdata_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bcd_q     <= bcd_d;
      supp_q    <= supp_d;
      txstart_q <= txstart_d;
      txdata_q  <= txdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign oTxStart = txstart_q;
  assign oTxData  = txdata_q;
  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oErr     = err_q;

endmodule

// File: tb/tb_dec_to_asc_tx.sv
// Directed bench for dec_to_asc_tx: one instance without and one with leading-zero suppression,
// each driving a scaled uart_tx busy model.
module tb_dec_to_asc_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start;
  logic [15:0] bcd0, bcd1;
  logic [1:0]  hold;
  logic [1:0]  txbusy;
  logic [1:0]  txstart, busy, done, err;
  logic [7:0]  txdata0, txdata1;

  logic [1:0]  pend;
  logic [1:0]  busy_m;
  int          cnt [2];

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  int          dc [2];
  int          dc_snap;

  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  dec_to_asc_tx #(.DIGITS(4), .APPEND_CRLF(1), .LZ_SUPPRESS(0)) dut0 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start[0]), .iBcd(bcd0), .iTxBusy(txbusy[0]),
    .oTxStart(txstart[0]), .oTxData(txdata0), .oBusy(busy[0]), .oDone(done[0]), .oErr(err[0])
  );

  dec_to_asc_tx #(.DIGITS(4), .APPEND_CRLF(1), .LZ_SUPPRESS(1)) dut1 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start[1]), .iBcd(bcd1), .iTxBusy(txbusy[1]),
    .oTxStart(txstart[1]), .oTxData(txdata1), .oBusy(busy[1]), .oDone(done[1]), .oErr(err[1])
  );

  assign txbusy = busy_m | hold;

  // uart_tx model: busy rises one cycle after the start pulse and lasts 10 cycles.
  initial begin
    pend   = '0;
    busy_m = '0;
    cnt[0] = 0;
    cnt[1] = 0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pend[k]) begin
        pend[k]   <= 1'b0;
        busy_m[k] <= 1'b1;
        cnt[k]    <= 10;
      end else if (cnt[k] > 0) begin
        cnt[k]    <= cnt[k] - 1;
        busy_m[k] <= (cnt[k] > 1);
      end
      if (txstart[k]) pend[k] <= 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (txstart[0]) q0.push_back(txdata0);
    if (txstart[1]) q1.push_back(txdata1);
    if (done[0]) dc[0]++;
    if (done[1]) dc[1]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input int which, input logic [15:0] val);
    @(negedge clk);
    dc_snap = dc[which];
    if (which == 0) begin q0.delete(); bcd0 = val; end
    else            begin q1.delete(); bcd1 = val; end
    start[which] = 1'b1;
    @(negedge clk);
    start[which] = 1'b0;
  endtask

  task automatic finish_frame(input int which, input string tag, input logic [63:0] exp, input int n);
    int sz;
    logic [7:0] got;
    for (int i = 0; i < 600; i++) begin
      if (dc[which] > dc_snap) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk({tag, "_done"}, dc[which] - dc_snap, 1);
    sz = (which == 0) ? q0.size() : q1.size();
    chk({tag, "_len"}, sz, n);
    for (int i = 0; i < n && i < sz; i++) begin
      got = (which == 0) ? q0[i] : q1[i];
      chk($sformatf("%s_ch%0d", tag, i), got, exp[8*(n-1-i) +: 8]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    hold  = '0;
    bcd0  = '0;
    bcd1  = '0;
    dc[0] = 0;
    dc[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_txstart", {30'd0, txstart}, 0);
    chk("rst_txdata",  {txdata1, txdata0}, 0);
    chk("rst_busy",    {30'd0, busy}, 0);
    chk("rst_done",    {30'd0, done}, 0);
    chk("rst_err",     {30'd0, err}, 0);
    rst_n = 1'b1;

    // 1: basic frame with latency checks
    @(negedge clk);
    dc_snap = dc[0];
    q0.delete();
    bcd0 = 16'h1234;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("t1_busy_n1", busy[0], 1);
    chk("t1_start_n1", txstart[0], 0);
    @(negedge clk);
    chk("t1_start_n2", txstart[0], 1);
    chk("t1_data_n2", txdata0, 8'h31);
    finish_frame(0, "t1", 64'h31_32_33_34_0D_0A, 6);
    chk("t1_err", err[0], 0);
    chk("t1_idle_busy", busy[0], 0);

    // 2: leading-zero suppression
    kick(1, 16'h0070);
    finish_frame(1, "t2a", 64'h37_30_0D_0A, 4);
    kick(1, 16'h0000);
    finish_frame(1, "t2b", 64'h30_0D_0A, 3);

    // 3: invalid digit and sticky error
    kick(0, 16'h12A4);
    finish_frame(0, "t3", 64'h31_32_3F_34_0D_0A, 6);
    chk("t3_err_set", err[0], 1);
    repeat (10) @(negedge clk);
    chk("t3_err_sticky", err[0], 1);
    kick(0, 16'h0001);
    chk("t3_err_clr", err[0], 0);
    finish_frame(0, "t3b", 64'h30_30_30_31_0D_0A, 6);

    // 4: repeated iStart and iBcd changes during a frame
    @(negedge clk);
    dc_snap = dc[0];
    q0.delete();
    bcd0 = 16'h1234;
    start[0] = 1'b1;
    @(negedge clk);
    bcd0 = 16'h9999;
    repeat (30) @(negedge clk);
    start[0] = 1'b0;
    finish_frame(0, "t4", 64'h31_32_33_34_0D_0A, 6);

    // 5: transmitter already busy when the request arrives
    @(negedge clk);
    hold[0] = 1'b1;
    kick(0, 16'h5678);
    repeat (20) @(negedge clk);
    chk("t5_no_start", q0.size(), 0);
    chk("t5_busy", busy[0], 1);
    hold[0] = 1'b0;
    @(negedge clk);
    chk("t5_start", txstart[0], 1);
    chk("t5_data", txdata0, 8'h35);
    finish_frame(0, "t5", 64'h35_36_37_38_0D_0A, 6);

    // 6: reset during the third character
    kick(0, 16'h1234);
    for (int i = 0; i < 300; i++) begin
      if (q0.size() >= 3) break;
      @(negedge clk);
    end
    chk("t6_reached3", q0.size(), 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_txstart", txstart[0], 0);
    chk("t6_txdata", txdata0, 0);
    chk("t6_busy", busy[0], 0);
    chk("t6_done", done[0], 0);
    chk("t6_err", err[0], 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_no_more", q0.size(), 3);
    chk("t6_no_done", dc[0] - dc_snap, 0);
    kick(0, 16'h1234);
    finish_frame(0, "t6b", 64'h31_32_33_34_0D_0A, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
